// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} loader_state_t;
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs incoming bytes little-endian into a 32-bit word; wordFull pulses for
// one cycle after the last byte of a word is shifted in.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shiftEn,
  input  logic [7:0]  byteData,
  output logic [31:0] word,
  output logic        lastByte,
  output logic        wordFull
);
  logic [1:0] byteCnt;

  assign lastByte = (byteCnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word     <= '0;
      byteCnt  <= '0;
      wordFull <= 1'b0;
    end else if (clr) begin
      word     <= '0;
      byteCnt  <= '0;
      wordFull <= 1'b0;
    end else begin
      wordFull <= shiftEn && lastByte;
      if (shiftEn) begin
        // Shift right so the first byte ends up in bits [7:0].
        word    <= {byteData, word[31:8]};
        byteCnt <= byteCnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives LEN/payload/CSUM over a byte stream, writes words into
// instruction memory and releases the core only after a verified image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wd,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  loader_state_t state;
  logic [15:0]   lenN;
  logic [7:0]    csum;
  logic [ADDR_W:0] wordsLoaded;
  logic [15:0]   lenNext;
  logic          startOk, shiftEn, lastByte, wordFull;
  logic [31:0]   packWord;

  assign startOk = start && (state == IDLE || state == DONE || state == ERR);
  assign shiftEn = (state == DATA) && byte_valid;
  assign lenNext = {byte_data, lenN[7:0]};

  byte_packer uPacker (
    .clk      (clk),
    .reset    (reset),
    .clr      (startOk),
    .shiftEn  (shiftEn),
    .byteData (byte_data),
    .word     (packWord),
    .lastByte (lastByte),
    .wordFull (wordFull)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lenN        <= '0;
      csum        <= '0;
      wordsLoaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state       <= LEN0;
          lenN        <= '0;
          csum        <= '0;
          wordsLoaded <= '0;
        end
        LEN0: if (byte_valid) begin
          lenN[7:0] <= byte_data;
          state     <= LEN1;
        end
        LEN1: if (byte_valid) begin
          lenN[15:8] <= byte_data;
          if ({1'b0, lenNext} > CAP) state <= ERR;
          else if (lenNext == 16'd0) state <= CSUM;
          else                       state <= DATA;
        end
        DATA: if (byte_valid) begin
          csum <= csum ^ byte_data;
          if (lastByte) state <= WRITE;
        end
        WRITE: begin
          wordsLoaded <= wordsLoaded + 1'b1;
          state <= (17'(wordsLoaded) + 17'd1 == {1'b0, lenN}) ? CSUM : DATA;
        end
        CSUM: if (byte_valid) state <= (byte_data == csum) ? DONE : ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly, so they change only on clk edges.
  assign byte_ready   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign imem_we      = wordFull;
  assign imem_wd      = packWord;
  assign imem_addr    = BASE_ADDR + (32'(wordsLoaded) << 2);
  assign core_hold    = (state != DONE);
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign words_loaded = wordsLoaded;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of images plus hand sequences for
// reset, overflow and restart corners; a narrow instance covers capacity limits.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h0;

  logic byte_ready, imem_we, core_hold, done, err;
  logic [31:0] imem_addr, imem_wd;
  logic [8:0] words_loaded;

  logic d2Ready, d2We, d2Hold, d2Done, d2Err;
  logic [31:0] d2Addr, d2Wd;
  logic [2:0] d2Wl;

  int total = 0, bad = 0;
  logic [63:0] wq[$];
  int w2cnt = 0;
  logic [63:0] w2last;

  typedef struct {
    logic [15:0]      n;
    logic [3:0][31:0] w;
    logic [7:0]       csum;
    logic             expDone;
    logic [8:0]       expWl;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .core_hold(core_hold), .done(done), .err(err), .words_loaded(words_loaded));

  imem_loader #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(d2Ready), .imem_we(d2We), .imem_addr(d2Addr), .imem_wd(d2Wd),
    .core_hold(d2Hold), .done(d2Done), .err(d2Err), .words_loaded(d2Wl));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (imem_we) begin
      chk("ready_in_write", 64'(byte_ready), 64'd0);
      wq.push_back({imem_addr, imem_wd});
    end
    if (d2We) begin
      chk("ready_in_write2", 64'(d2Ready), 64'd0);
      w2cnt++;
      w2last = {d2Addr, d2Wd};
    end
    if (done || err) chk("done_err_excl", 64'(done && err), 64'd0);
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    bit acc = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_data = b;
    byte_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = byte_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    if (!acc) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic loadImage(input vec_t v, input bit doStart);
    if (doStart) pulseStart();
    chk("start_hold", 64'(core_hold), 64'd1);
    chk("start_wl", 64'(words_loaded), 64'd0);
    wq.delete();
    sendByte(v.n[7:0]);
    sendByte(v.n[15:8]);
    for (int i = 0; i < int'(v.n); i++) begin
      for (int k = 0; k < 4; k++) sendByte(v.w[i][8*k +: 8]);
      @(negedge clk);
      chk("we_latency", 64'(imem_we), 64'd1);
      byte_valid = 1'b0;
    end
    sendByte(v.csum);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    // Payload XOR of 0x00500093/0x00100113 is 0xC1.
    tbl[0] = '{16'd2, {32'h0, 32'h0, 32'h00100113, 32'h00500093}, 8'hC1, 1'b1, 9'd2};
    tbl[1] = '{16'd2, {32'h0, 32'h0, 32'h00100113, 32'h00500093}, 8'h00, 1'b0, 9'd2};
    tbl[2] = '{16'd2, {32'h0, 32'h0, 32'h00100113, 32'h00500093}, 8'hC2, 1'b0, 9'd2};
    tbl[3] = '{16'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b1, 9'd0};
    tbl[4] = '{16'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h01, 1'b0, 9'd0};
    tbl[5] = '{16'd3, {32'h0, 32'h0000FFFF, 32'h12345678, 32'hDEADBEEF}, 8'h2A, 1'b1, 9'd3};
    tbl[6] = '{16'd4, {32'h4, 32'h3, 32'h2, 32'h1}, 8'h04, 1'b1, 9'd4};

    #2 reset = 1'b0;
    #2;
    chk("rst_hold", 64'(core_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_wl", 64'(words_loaded), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 7; t++) begin
      loadImage(tbl[t], 1'b1);
      chk($sformatf("v%0d_done", t), 64'(done), 64'(tbl[t].expDone));
      chk($sformatf("v%0d_err", t), 64'(err), 64'(!tbl[t].expDone));
      chk($sformatf("v%0d_hold", t), 64'(core_hold), 64'(!tbl[t].expDone));
      chk($sformatf("v%0d_wl", t), 64'(words_loaded), 64'(tbl[t].expWl));
      chk($sformatf("v%0d_nwr", t), 64'(wq.size()), 64'(tbl[t].n));
      for (int i = 0; i < wq.size() && i < 4; i++)
        chk($sformatf("v%0d_wr%0d", t, i), wq[i], {32'(4 * i), tbl[t].w[i]});
      chk($sformatf("v%0d_d2done", t), 64'(d2Done), 64'(tbl[t].expDone));
      chk($sformatf("v%0d_d2wl", t), 64'(d2Wl), 64'(tbl[t].expWl[2:0]));
    end
    chk("d2_full_last", w2last, {32'hC, 32'h4});

    // Length overflow on the 4-word instance.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    w2cnt = 0;
    pulseStart();
    sendByte(8'h05);
    sendByte(8'h00);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("ovf_err", 64'(d2Err), 64'd1);
    chk("ovf_hold", 64'(d2Hold), 64'd1);
    repeat (3) @(negedge clk);
    chk("ovf_nowrite", 64'(w2cnt), 64'd0);

    // Reset mid-load after 6 payload bytes, then a clean reload.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    pulseStart();
    sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h93); sendByte(8'h00); sendByte(8'h50); sendByte(8'h00);
    sendByte(8'h13); sendByte(8'h01);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_hold", 64'(core_hold), 64'd1);
    chk("mid_rst_ready", 64'(byte_ready), 64'd0);
    chk("mid_rst_wl", 64'(words_loaded), 64'd0);
    chk("mid_rst_de", 64'({done, err, imem_we}), 64'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    loadImage(tbl[0], 1'b1);
    chk("reload_done", 64'(done), 64'd1);
    chk("reload_nwr", 64'(wq.size()), 64'd2);

    // Start mid-DATA is ignored; start in DONE restarts.
    pulseStart();
    wq.delete();
    sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h93); sendByte(8'h00); sendByte(8'h50); sendByte(8'h00);
    sendByte(8'h13);
    pulseStart();
    chk("ign_start_wl", 64'(words_loaded), 64'd1);
    chk("ign_start_ready", 64'(byte_ready), 64'd1);
    sendByte(8'h01); sendByte(8'h10); sendByte(8'h00);
    sendByte(8'hC1);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_wl", 64'(words_loaded), 64'd2);
    chk("ign_nwr", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) chk("ign_wr1", wq[1], {32'h4, 32'h00100113});
    pulseStart();
    chk("restart_hold", 64'(core_hold), 64'd1);
    chk("restart_done", 64'(done), 64'd0);
    loadImage(tbl[5], 1'b0);
    chk("restart_fin", 64'({done, err, core_hold}), 64'b100);
    chk("restart_wl", 64'(words_loaded), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
